// File: rtl/serial_pkg.sv
// Shared definitions for the serial link between the bit serializer and the
// downstream sequence detector.
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int SER_DEFAULT_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/ser_hold_reg.sv
// Single-entry holding register that parks the next word while the shifter
// is still busy with the current one.
module ser_hold_reg
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             unload,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   // Occupancy flag: set on load, cleared when the shifter takes the word.
   // Load and unload never coincide because loads are refused while full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
      end else if (unload) begin
         full <= 1'b0;
      end
   end

   // Payload storage; meaningless while empty, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         dout <= din;
      end
   end

endmodule : ser_hold_reg

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector. Words arrive
// over valid/ready, leave one bit per clock, and a one-word holding register
// lets consecutive words stream without a gap.
module bit_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   ser_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             accept;
   logic             last_bit;
   logic             hold_load;
   logic             hold_unload;

   // Advance the shifter so the next bit to send lands on the output end.
   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
      if (MSB_FIRST) begin
         return {v[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, v[WIDTH-1:1]};
      end
   endfunction

   // Readiness depends only on registered state, never on in_valid.
   assign in_ready = !hold_full;
   assign accept   = in_valid && in_ready;
   assign last_bit = (cnt == LAST_CNT);

   // A word goes to the hold register only when the shifter cannot take it
   // this edge; on the last bit an accepted word bypasses the hold register.
   assign hold_load   = accept && (state == SHIFT) && !last_bit;
   assign hold_unload = (state == SHIFT) && last_bit && hold_full;

   ser_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (hold_load),
      .unload  (hold_unload),
      .din     (in_data),
      .dout    (hold_data),
      .full    (hold_full)
   );

   // Control FSM and bit counter; the counter restarts whenever a new word
   // enters the shifter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= SHIFT;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               if (last_bit) begin
                  cnt <= '0;
                  if (!hold_full && !accept) begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Shift register datapath; priority on the last bit is hold first, then
   // a direct load, so word order is preserved.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (accept) begin
            shreg <= in_data;
         end
      end else if (last_bit) begin
         if (hold_full) begin
            shreg <= hold_data;
         end else if (accept) begin
            shreg <= in_data;
         end
      end else begin
         shreg <= shift_one(shreg);
      end
   end

   // Output decode from registered state only; reset forces idle fill at once.
   assign out_valid   = (state == SHIFT);
   assign frame_start = out_valid && (cnt == '0);
   assign busy        = out_valid || hold_full;
   assign out_bit     = out_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                  : IDLE_BIT;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first / idle-0 instance and one
// LSB-first / idle-1 instance sharing clock and reset.
module tb_bit_serializer;

   logic       clk;
   logic       reset_n;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       out_bit;
   logic       out_valid;
   logic       frame_start;
   logic       busy;

   logic [7:0] in_data2;
   logic       in_valid2;
   logic       in_ready2;
   logic       out_bit2;
   logic       out_valid2;
   logic       frame_start2;
   logic       busy2;

   int         n_assert;
   int         n_fail;

   logic       collect;
   logic       q[$];

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_bit     (out_bit),
      .out_valid   (out_valid),
      .frame_start (frame_start),
      .busy        (busy)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_data     (in_data2),
      .in_valid    (in_valid2),
      .in_ready    (in_ready2),
      .out_bit     (out_bit2),
      .out_valid   (out_valid2),
      .frame_start (frame_start2),
      .busy        (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record serial bits mid-cycle while enabled.
   always @(negedge clk) begin
      if (collect && out_valid) q.push_back(out_bit);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0]  w_a5;
      logic [15:0] w_pair;
      logic [7:0]  words [3];
      logic [7:0]  got;
      logic [7:0]  w_det;
      logic [3:0]  sr;
      logic        acc;
      int          idx;
      int          cyc;
      int          det_cnt;
      int          det_idx;

      n_assert  = 0;
      n_fail    = 0;
      collect   = 1'b0;
      reset_n   = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_data2  = '0;
      in_valid2 = 1'b0;
      w_a5      = 8'hA5;
      w_pair    = 16'hA53C;
      words[0]  = 8'h5A;
      words[1]  = 8'hC3;
      words[2]  = 8'h96;
      w_det     = 8'b0001_0100;

      // Reset values
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_out_bit_lsb", out_bit2, 1);
      #9 reset_n = 1'b1;
      step();

      // Single word A5, MSB first
      in_valid = 1'b1;
      in_data  = w_a5;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("single_bit%0d", i), out_bit, w_a5[7-i]);
         chk($sformatf("single_vld%0d", i), out_valid, 1);
         chk($sformatf("single_fs%0d", i), frame_start, (i == 0) ? 1 : 0);
         step();
      end
      chk("single_idle_vld", out_valid, 0);
      chk("single_idle_bit", out_bit, 0);
      chk("single_idle_busy", busy, 0);

      // Back-to-back A5 then 3C
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step();
      in_data  = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("b2b_bit%0d", i), out_bit, w_pair[15-i]);
         chk($sformatf("b2b_vld%0d", i), out_valid, 1);
         chk($sformatf("b2b_fs%0d", i), frame_start, (i == 0 || i == 8) ? 1 : 0);
         chk($sformatf("b2b_rdy%0d", i), in_ready, (i == 0 || i >= 8) ? 1 : 0);
         step();
         if (i == 0) in_valid = 1'b0;
      end
      chk("b2b_idle_vld", out_valid, 0);
      chk("b2b_idle_bit", out_bit, 0);

      // LSB first with idle level 1
      in_valid2 = 1'b1;
      in_data2  = 8'h01;
      step();
      in_valid2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb_bit%0d", i), out_bit2, (i == 0) ? 1 : 0);
         chk($sformatf("lsb_vld%0d", i), out_valid2, 1);
         chk($sformatf("lsb_fs%0d", i), frame_start2, (i == 0) ? 1 : 0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lsb_idle_bit%0d", i), out_bit2, 1);
         chk($sformatf("lsb_idle_vld%0d", i), out_valid2, 0);
         step();
      end

      // Backpressure with random valid toggling
      q.delete();
      collect = 1'b1;
      idx = 0;
      cyc = 0;
      while (idx < 3 && cyc < 300) begin
         in_valid = (cyc == 0) || ($urandom_range(0, 1) == 1);
         in_data  = words[idx];
         acc      = in_valid && in_ready;
         step();
         cyc++;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("bp_accepts", idx, 3);
      cyc = 0;
      while (busy && cyc < 100) begin
         step();
         cyc++;
      end
      chk("bp_drained", busy, 0);
      step();
      collect = 1'b0;
      chk("bp_bit_count", q.size(), 24);
      if (q.size() == 24) begin
         for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 8; j++) got[7-j] = q[w*8+j];
            chk($sformatf("bp_word%0d", w), got, words[w]);
         end
      end

      // Reset asserted mid-word
      in_valid = 1'b1;
      in_data  = 8'hFF;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("mid_pre_vld", out_valid, 1);
      chk("mid_pre_bit", out_bit, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_vld", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_fs", frame_start, 0);
      chk("mid_rst_bit", out_bit, 0);
      chk("mid_rst_rdy", in_ready, 1);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("mid_post_vld%0d", i), out_valid, 0);
         chk($sformatf("mid_post_bit%0d", i), out_bit, 0);
         step();
      end

      // Stream into a reference 1010 detector
      q.delete();
      collect  = 1'b1;
      in_valid = 1'b1;
      in_data  = w_det;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      collect = 1'b0;
      chk("det_bit_count", q.size(), 8);
      sr      = 4'b0000;
      det_cnt = 0;
      det_idx = -1;
      for (int i = 0; i < q.size(); i++) begin
         chk($sformatf("det_bit%0d", i), q[i], w_det[7-i]);
         sr = {sr[2:0], q[i]};
         if (i >= 3 && sr == 4'b1010) begin
            det_cnt++;
            det_idx = i;
         end
      end
      chk("det_count", det_cnt, 1);
      chk("det_index", det_idx, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial stage that sits directly upstream of the sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock on `out_bit`, which connects to the detector's serial input. A single-entry holding register lets consecutive words stream with no idle gap. When no data is pending, the line is driven with a fixed idle level.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `IDLE_BIT`, 0: level driven on `out_bit` when no word is being shifted.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  parallel word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `out_bit`  out  1  serial data to the detector.
- `out_valid`  out  1  `out_bit` carries a data bit (not idle fill).
- `frame_start`  out  1  high while the first bit of a word is on `out_bit`.
- `busy`  out  1  shifter or holding register is occupied.

## Operation
- Transfer occurs at a rising edge when `in_valid && in_ready`. `in_ready = !hold_full`; it is purely combinational from registered state, with no dependency on `in_valid`.
- FSM states: IDLE and SHIFT.
  - IDLE: shifter empty. An accepted word loads straight into the shifter, bit counter = 0, next state SHIFT.
  - SHIFT: each edge advances one bit and increments the bit counter (width `$clog2(WIDTH)`).
- Last bit in SHIFT (counter = WIDTH-1):
  - If hold is full: move hold into the shifter, counter = 0, stay in SHIFT, clear hold_full.
  - Else if a transfer occurs at this edge: load `in_data` directly into the shifter, stay in SHIFT.
  - Otherwise: go to IDLE.
- Not last bit in SHIFT: an accepted word goes into the holding register and sets hold_full.
- Output selection: the bit on `out_bit` is taken from the shift register MSB if `MSB_FIRST`=1, else from the LSB. The register shifts in the matching direction.
- `out_valid` = (state == SHIFT). `frame_start` = SHIFT && counter == 0. `busy` = SHIFT || hold_full.
- In IDLE, `out_bit` = `IDLE_BIT`.
- Upstream must hold `in_data` stable while `in_valid && !in_ready`. The block never accepts a word twice and never drops one.

## Timing
- Reset values (applied asynchronously while `reset_n` = 0):
  - state = IDLE, hold_full = 0, counter = 0.
  - `out_bit` = `IDLE_BIT`, `out_valid` = 0, `frame_start` = 0, `busy` = 0, `in_ready` = 1.
- Latency: a word accepted at edge k drives its first bit on `out_bit` from edge k to edge k+1. Its last bit is shown from edge k+WIDTH-1 to edge k+WIDTH.
- Throughput: one bit per cycle, sustained. Back-to-back words produce contiguous `out_valid`, with `frame_start` every WIDTH cycles.
- `in_ready` falls the cycle after the hold register fills. It rises one cycle after the hold contents move to the shifter.
- Reset mid-word: shifter and hold contents are discarded. Outputs return to idle values immediately, with no partial-word completion after release.
- All outputs are registered or decoded from registers only. There is no combinational path from `in_valid`/`in_data` to `out_*`.

## Structure
- Shared package `serial_pkg`: `ser_state_t` enum {IDLE, SHIFT} and the `SER_DEFAULT_WIDTH` constant. The package is reused by the detector bench.
- One sub-module is natural: `ser_hold_reg`. It is the single-entry holding register with load, unload, and full flag.
- The FSM, counter and shifter remain in `bit_serializer`.

## Test plan
- **Single word:** reset, then send 8'hA5 with `MSB_FIRST`=1. Required: `out_bit` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; `out_valid` high for exactly those 8 cycles; `frame_start` high on the first cycle only; `out_bit` = `IDLE_BIT` afterwards.
- **Back-to-back:** hold `in_valid` with 8'hA5 then 8'h3C. Required: 16 contiguous valid bits 10100101 00111100; `in_ready` low from the cycle after the second accept until the 3C load; `frame_start` at cycles 0 and 8.
- **LSB-first and idle fill:** `MSB_FIRST`=0, `IDLE_BIT`=1, send 8'h01. Required: `out_bit` = 1,0,0,0,0,0,0,0, then a constant 1 with `out_valid` = 0.
- **Backpressure:** present 3 words while the shifter is busy; toggle `in_valid` randomly; change `in_data` only after acceptance. Required: exactly 3 words are serialized, in order, with no duplicates.
- **Reset mid-word:** assert `reset_n` = 0 at bit 3 of 8'hFF. Required: `out_valid`, `busy` and `frame_start` go to 0 and `out_bit` goes to `IDLE_BIT` without waiting for a clock; after release, no remaining bits of 8'hFF appear.
- **Detector integration:** serialize 8'b0001_0100 MSB-first into the sequence detector. Required: the detector's `detected` asserts exactly once, on the bit following the 1,0,1,0 run.
